risac_avalon_mem_slave: RTL and testbench

- Avalon-MM slave (responder) data memory: the target end of the CPU's Avalon data bus.
- Word-organised RAM with byte-enable writes.
- Inserts a fixed, parameterised number of wait states via waitrequest.
- Returns full aligned 32-bit words; the master performs sub-word shifting, so no lane steering is done here.

---
 rtl/risac_avalon_pkg.sv | 13 +
 rtl/risac_be_spram.sv | 33 +++
 rtl/risac_avalon_mem_slave.sv | 98 +++++++++
 tb/tb_risac_avalon_mem_slave.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/risac_avalon_pkg.sv
// Shared types and constants for the Avalon-MM data-memory slave.
package risac_avalon_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int WAIT_CNT_W = 4;
   localparam int BYTE_LANES = 4;

endpackage

// File: rtl/risac_be_spram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module risac_be_spram
   import risac_avalon_pkg::*;
#(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [ADDR_WIDTH-1:0]   addr,
   input  logic                    we,
   input  logic [BYTE_LANES-1:0]   be,
   input  logic [BYTE_LANES*8-1:0] wdata,
   input  logic                    re,
   output logic [BYTE_LANES*8-1:0] rdata
);

   logic [BYTE_LANES*8-1:0] mem [0:(1<<ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BYTE_LANES; i++) begin
            if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Output register only is reset; the array itself keeps its contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)  rdata <= '0;
      else if (re) rdata <= mem[addr];
   end

endmodule

// File: rtl/risac_avalon_mem_slave.sv
// Avalon-MM slave data memory: fixed wait-state handshake in front of a byte-enable RAM.
module risac_avalon_mem_slave
   import risac_avalon_pkg::*;
#(
   parameter int ADDR_WIDTH  = 10,
   parameter int WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] avs_address,
   input  logic        avs_read,
   input  logic        avs_write,
   input  logic [31:0] avs_writedata,
   input  logic [3:0]  avs_byteenable,
   output logic [31:0] avs_readdata,
   output logic        avs_waitrequest
);

   if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("risac_avalon_mem_slave: WAIT_STATES must be in 1..15");
   end

   localparam logic [WAIT_CNT_W-1:0] LAST_CNT = WAIT_CNT_W'(WAIT_STATES - 1);

   state_t                  state;
   logic [WAIT_CNT_W-1:0]   cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [ADDR_WIDTH-1:0]   word_addr;
   logic [ADDR_WIDTH-1:0]   ram_addr;
   logic                    cmd;
   logic                    to_ack;
   logic                    ram_re;
   logic                    ram_we;
   logic                    unused_addr_bits;

   assign cmd              = avs_read | avs_write;
   assign avs_waitrequest  = cmd & (state != ACK);
   assign word_addr        = avs_address[ADDR_WIDTH+1:2];
   assign unused_addr_bits = ^{avs_address[31:ADDR_WIDTH+2], avs_address[1:0]};

   always_comb begin
      to_ack = 1'b0;
      case (state)
         IDLE:    to_ack = cmd && (WAIT_STATES == 1);
         WAIT:    to_ack = cmd && (cnt == LAST_CNT);
         default: to_ack = 1'b0;
      endcase
   end

   // In IDLE the address has not been latched yet, so a single-wait read uses it directly.
   assign ram_addr = (state == IDLE) ? word_addr : addr_q;
   assign ram_re   = to_ack & avs_read & ~avs_write;
   assign ram_we   = (state == ACK) & avs_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd) begin
                  cnt   <= WAIT_CNT_W'(1);
                  state <= to_ack ? ACK : WAIT;
               end
            end
            WAIT: begin
               if (!cmd) begin
                  state <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
                  if (to_ack) state <= ACK;
               end
            end
            ACK:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == IDLE && cmd) addr_q <= word_addr;
   end

   risac_be_spram #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .rst_n (rst_n),
      .addr  (ram_addr),
      .we    (ram_we),
      .be    (avs_byteenable),
      .wdata (avs_writedata),
      .re    (ram_re),
      .rdata (avs_readdata)
   );

endmodule

// File: tb/tb_risac_avalon_mem_slave.sv
// Bench for risac_avalon_mem_slave: one instance with two wait states, one with a single wait state.
module tb_risac_avalon_mem_slave;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] address     [2];
   logic        read        [2];
   logic        write       [2];
   logic [31:0] writedata   [2];
   logic [3:0]  byteenable  [2];
   logic [31:0] readdata    [2];
   logic        waitrequest [2];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   risac_avalon_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(2)) u_dut2 (
      .clk             (clk),
      .rst_n           (rst_n),
      .avs_address     (address[0]),
      .avs_read        (read[0]),
      .avs_write       (write[0]),
      .avs_writedata   (writedata[0]),
      .avs_byteenable  (byteenable[0]),
      .avs_readdata    (readdata[0]),
      .avs_waitrequest (waitrequest[0])
   );

   risac_avalon_mem_slave #(.ADDR_WIDTH(10), .WAIT_STATES(1)) u_dut1 (
      .clk             (clk),
      .rst_n           (rst_n),
      .avs_address     (address[1]),
      .avs_read        (read[1]),
      .avs_write       (write[1]),
      .avs_writedata   (writedata[1]),
      .avs_byteenable  (byteenable[1]),
      .avs_readdata    (readdata[1]),
      .avs_waitrequest (waitrequest[1])
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int ws(input int k);
      return (k == 0) ? 2 : 1;
   endfunction

   // Reference: a transaction is ws(k) stalled cycles then one completing cycle.
   logic [31:0] mem_m  [2][0:1023];
   int          m_cnt  [2];
   logic [9:0]  m_addr [2];
   logic [31:0] exp_rd [2];

   always @(posedge clk or negedge rst_n) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n) begin
            m_cnt[k]  <= 0;
            exp_rd[k] <= '0;
         end else if (read[k] || write[k]) begin
            if (m_cnt[k] == ws(k)) begin
               if (write[k]) begin
                  for (int b = 0; b < 4; b++)
                     if (byteenable[k][b]) mem_m[k][m_addr[k]][8*b +: 8] <= writedata[k][8*b +: 8];
               end
               m_cnt[k] <= 0;
            end else begin
               if (m_cnt[k] == 0) m_addr[k] <= address[k][11:2];
               if (m_cnt[k] == ws(k) - 1 && read[k] && !write[k])
                  exp_rd[k] <= mem_m[k][(m_cnt[k] == 0) ? address[k][11:2] : m_addr[k]];
               m_cnt[k] <= m_cnt[k] + 1;
            end
         end else begin
            m_cnt[k] <= 0;
         end
      end
   end

   initial begin
      @(posedge clk);
      forever begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            check($sformatf("cyc_waitreq%0d", k), 32'(waitrequest[k]),
                  32'((read[k] || write[k]) && (m_cnt[k] != ws(k))));
            check($sformatf("cyc_readdata%0d", k), readdata[k], exp_rd[k]);
         end
      end
   end

   // Starts at posedge+1, returns at posedge+1 with the request dropped.
   task automatic xact(input int k, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       output logic [31:0] rdv, output logic [15:0] pat, output int n);
      logic done;
      address[k]    = a;
      writedata[k]  = d;
      byteenable[k] = be;
      read[k]       = rd;
      write[k]      = wr;
      pat  = '0;
      n    = 0;
      rdv  = '0;
      done = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         pat = {pat[14:0], waitrequest[k]};
         n++;
         if (!waitrequest[k]) begin
            rdv  = readdata[k];
            done = 1'b1;
            break;
         end
      end
      check("xact_completes", 32'(done), 32'd1);
      @(posedge clk);
      #1;
      read[k]  = 1'b0;
      write[k] = 1'b0;
   endtask

   logic [31:0] r, r2, wv;
   logic [15:0] p, p2;
   int          n, n2;
   int          w;
   logic [31:0] a;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         address[k] = '0; read[k] = 1'b0; write[k] = 1'b0;
         writedata[k] = '0; byteenable[k] = '0;
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("reset_readdata2", readdata[0], 32'h0);
      check("reset_readdata1", readdata[1], 32'h0);
      check("reset_waitreq_idle", 32'(waitrequest[0]), 32'd0);

      // Full-word write and read-back, two wait states.
      xact(0, 1'b0, 1'b1, 32'h010, 32'hDEADBEEF, 4'hF, r, p, n);
      check("wr_pattern", {n[15:0], p}, {16'd3, 16'b110});
      xact(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, r, p, n);
      check("rd_pattern", {n[15:0], p}, {16'd3, 16'b110});
      check("rd_deadbeef", r, 32'hDEADBEEF);

      xact(0, 1'b0, 1'b1, 32'h010, 32'h0000AA00, 4'b0010, r, p, n);
      xact(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, r, p, n);
      check("rd_byte1_merge", r, 32'hDEADAAEF);
      xact(0, 1'b0, 1'b1, 32'h010, 32'hFFFFFFFF, 4'b0000, r, p, n);
      check("be0_pattern", {n[15:0], p}, {16'd3, 16'b110});
      xact(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, r, p, n);
      check("rd_after_be0", r, 32'hDEADAAEF);

      // Aliasing and back-to-back reads.
      xact(0, 1'b0, 1'b1, 32'h010, 32'h12345678, 4'hF, r, p, n);
      xact(0, 1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, r, p, n);
      check("rd_alias", r, 32'h12345678);
      xact(0, 1'b1, 1'b0, 32'h1010, 32'h0, 4'h0, r, p, n);
      xact(0, 1'b1, 1'b0, 32'h010, 32'h0, 4'h0, r2, p2, n2);
      check("b2b_cycles", 32'(n + n2), 32'd6);
      check("b2b_pattern", {26'b0, p[2:0], p2[2:0]}, 32'b110110);
      check("b2b_data", r2, 32'h12345678);

      // Request withdrawn after one stalled cycle.
      xact(0, 1'b0, 1'b1, 32'h020, 32'hCAFEF00D, 4'hF, r, p, n);
      address[0] = 32'h020; writedata[0] = 32'h99999999; byteenable[0] = 4'hF; write[0] = 1'b1;
      @(negedge clk);
      check("drop_waitreq", 32'(waitrequest[0]), 32'd1);
      @(posedge clk); #1 write[0] = 1'b0;
      @(posedge clk); #1;
      xact(0, 1'b1, 1'b0, 32'h020, 32'h0, 4'h0, r, p, n);
      check("drop_pattern", {n[15:0], p}, {16'd3, 16'b110});
      check("drop_no_write", r, 32'hCAFEF00D);

      // Read and write together behave as a write.
      xact(0, 1'b1, 1'b1, 32'h024, 32'h0BADC0DE, 4'hF, r, p, n);
      check("rw_readdata_held", r, 32'hCAFEF00D);
      xact(0, 1'b1, 1'b0, 32'h024, 32'h0, 4'h0, r, p, n);
      check("rw_wrote", r, 32'h0BADC0DE);

      // Asynchronous reset in the middle of a write.
      xact(0, 1'b0, 1'b1, 32'h030, 32'h11112222, 4'hF, r, p, n);
      address[0] = 32'h030; writedata[0] = 32'h00000055; byteenable[0] = 4'hF; write[0] = 1'b1;
      @(negedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1 check("midreset_readdata", readdata[0], 32'h0);
      @(negedge clk);
      check("midreset_waitreq", 32'(waitrequest[0]), 32'd1);
      @(posedge clk); #1;
      write[0] = 1'b0;
      rst_n    = 1'b1;
      xact(0, 1'b1, 1'b0, 32'h030, 32'h0, 4'h0, r, p, n);
      check("postreset_pattern", {n[15:0], p}, {16'd3, 16'b110});
      check("postreset_mem", r, 32'h11112222);

      // Single wait state instance.
      xact(1, 1'b0, 1'b1, 32'h008, 32'hA5A50F0F, 4'hF, r, p, n);
      check("ws1_wr_pattern", {n[15:0], p}, {16'd2, 16'b10});
      xact(1, 1'b1, 1'b0, 32'h008, 32'h0, 4'h0, r, p, n);
      check("ws1_rd_pattern", {n[15:0], p}, {16'd2, 16'b10});
      check("ws1_rd_data", r, 32'hA5A50F0F);

      for (int i = 0; i < 16; i++) begin
         xact(1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, r, p, n);
      end
      for (int i = 0; i < 200; i++) begin
         w  = $urandom_range(0, 15);
         a  = ($urandom & ~32'h0000_0FFC) | 32'(w << 2);
         wv = $urandom;
         case ($urandom_range(0, 5))
            0, 1, 2: xact(1, 1'b1, 1'b0, a, wv, 4'($urandom), r, p, n);
            3, 4:    xact(1, 1'b0, 1'b1, a, wv, 4'($urandom), r, p, n);
            default: xact(1, 1'b1, 1'b1, a, wv, 4'($urandom), r, p, n);
         endcase
         check("ws1_rand_pattern", {n[15:0], p}, {16'd2, 16'b10});
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
      end

      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
